// File: rtl/stage_1_pkg.sv
// Shared widths, defaults and address/legality helpers for the stage-1 pipe.
package stage_1_pkg;

  localparam int unsigned RANGE_WIDTH_D    = 16;
  localparam int unsigned SYMBOL_WIDTH_D   = 4;
  localparam int unsigned LUT_DATA_WIDTH_D = 16;
  localparam int unsigned CDF_SHIFT_D      = 6;
  localparam int unsigned CNT_WIDTH_D      = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } occ_e;

  // {(nsyms-1) mod 2^sw, symbol mod 2^sw}; nsyms==0 wraps to all ones.
  function automatic logic [31:0] lut_addr_f(input int unsigned nsyms,
                                             input int unsigned symbol,
                                             input int unsigned sw);
    int unsigned mask;
    mask = (32'd1 << sw) - 32'd1;
    return (((nsyms - 32'd1) & mask) << sw) | (symbol & mask);
  endfunction

  function automatic logic sym_illegal_f(input int unsigned nsyms,
                                         input int unsigned symbol,
                                         input int unsigned sw);
    return (nsyms == 32'd0) || (nsyms > (32'd1 << sw)) || (symbol >= nsyms);
  endfunction

endpackage

// File: rtl/lut_u.sv
// U-word lookup table, synchronous read with one cycle of latency.
module lut_u #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    data <= DATA_WIDTH'(32'(addr) * 32'd37 + 32'd11);
  end

endmodule

// File: rtl/lut_v.sv
// V-word lookup table, synchronous read with one cycle of latency.
module lut_v #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    data <= DATA_WIDTH'((32'(addr) << 5) ^ 32'h0000_A5C3);
  end

endmodule

// File: rtl/stage_1_addr_hold.sv
// LUT address mux: new address on accept, otherwise the held address of the
// current output record so the synchronous LUT words stay stable in a stall.
module stage_1_addr_hold #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic [ADDR_WIDTH-1:0] new_addr,
  output logic [ADDR_WIDTH-1:0] lut_addr
);

  logic [ADDR_WIDTH-1:0] held_q;

  always_ff @(posedge clk) begin
    if (reset)       held_q <= '0;
    else if (accept) held_q <= new_addr;
  end

  assign lut_addr = accept ? new_addr : held_q;

endmodule

// File: rtl/stage_1_pipe.sv
// Encoder stage 1: registered CDF shift, compare flag and U/V LUT lookup
// behind a one-deep valid/ready register slice.
module stage_1_pipe
  import stage_1_pkg::*;
#(
  parameter int unsigned RANGE_WIDTH    = RANGE_WIDTH_D,
  parameter int unsigned SYMBOL_WIDTH   = SYMBOL_WIDTH_D,
  parameter int unsigned LUT_DATA_WIDTH = LUT_DATA_WIDTH_D,
  parameter int unsigned CDF_SHIFT      = CDF_SHIFT_D,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_D
) (
  input  logic                      clk_stage_1,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [RANGE_WIDTH-1:0]    FL,
  input  logic [RANGE_WIDTH-1:0]    FH,
  input  logic [SYMBOL_WIDTH-1:0]   SYMBOL,
  input  logic [SYMBOL_WIDTH:0]     NSYMS,
  input  logic                      bool,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RANGE_WIDTH-1:0]    UU,
  output logic [RANGE_WIDTH-1:0]    VV,
  output logic                      COMP_mux_1,
  output logic                      bool_out,
  output logic [SYMBOL_WIDTH-1:0]   out_symbol,
  output logic [LUT_DATA_WIDTH-1:0] lut_u_out,
  output logic [LUT_DATA_WIDTH-1:0] lut_v_out,
  output logic                      illegal,
  output logic [CNT_WIDTH-1:0]      sym_count
);

  localparam int unsigned LUT_ADDR_WIDTH = 2 * SYMBOL_WIDTH;

  occ_e                      state_q, state_d;
  logic                      accept, xfer;
  logic [LUT_ADDR_WIDTH-1:0] new_addr, lut_addr;

  assign out_valid = (state_q == FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge clk_stage_1) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)    state_d = FULL;
    else if (xfer) state_d = EMPTY;
  end

  always_ff @(posedge clk_stage_1) begin
    if (reset) begin
      UU         <= '0;
      VV         <= '0;
      COMP_mux_1 <= 1'b0;
      bool_out   <= 1'b0;
      out_symbol <= '0;
      illegal    <= 1'b0;
      sym_count  <= '0;
    end else if (accept) begin
      UU         <= FL >> CDF_SHIFT;
      VV         <= FH >> CDF_SHIFT;
      COMP_mux_1 <= ~FL[RANGE_WIDTH-1];
      bool_out   <= ~bool;
      out_symbol <= SYMBOL;
      sym_count  <= sym_count + CNT_WIDTH'(1);
      if (sym_illegal_f(32'(NSYMS), 32'(SYMBOL), SYMBOL_WIDTH))
        illegal <= 1'b1;
    end
  end

  assign new_addr = LUT_ADDR_WIDTH'(lut_addr_f(32'(NSYMS), 32'(SYMBOL), SYMBOL_WIDTH));

  stage_1_addr_hold #(
    .ADDR_WIDTH(LUT_ADDR_WIDTH)
  ) u_addr_hold (
    .clk      (clk_stage_1),
    .reset    (reset),
    .accept   (accept),
    .new_addr (new_addr),
    .lut_addr (lut_addr)
  );

  lut_u #(
    .ADDR_WIDTH(LUT_ADDR_WIDTH),
    .DATA_WIDTH(LUT_DATA_WIDTH)
  ) u_lut_u (
    .clk  (clk_stage_1),
    .addr (lut_addr),
    .data (lut_u_out)
  );

  lut_v #(
    .ADDR_WIDTH(LUT_ADDR_WIDTH),
    .DATA_WIDTH(LUT_DATA_WIDTH)
  ) u_lut_v (
    .clk  (clk_stage_1),
    .addr (lut_addr),
    .data (lut_v_out)
  );

endmodule

// File: tb/tb_stage_1_pipe.sv
// Directed bench for stage_1_pipe: default instance plus a 24-bit/shift-8 one.
module tb_stage_1_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] fl, fh, uu, vv, lu, lv;
  logic [3:0]  symbol, out_symbol;
  logic [4:0]  nsyms;
  logic        bool_in, bool_out, comp, illegal;
  logic [31:0] sym_count;

  logic        in_valid24, in_ready24, out_valid24, out_ready24;
  logic [23:0] fl24, fh24, uu24, vv24;
  logic        comp24, bool_out24, illegal24;
  logic [3:0]  out_symbol24;
  logic [15:0] lu24, lv24;
  logic [31:0] sym_count24;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  stage_1_pipe u_dut (
    .clk_stage_1(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .FL(fl), .FH(fh), .SYMBOL(symbol), .NSYMS(nsyms), .bool(bool_in),
    .out_valid(out_valid), .out_ready(out_ready), .UU(uu), .VV(vv),
    .COMP_mux_1(comp), .bool_out(bool_out), .out_symbol(out_symbol),
    .lut_u_out(lu), .lut_v_out(lv), .illegal(illegal), .sym_count(sym_count)
  );

  stage_1_pipe #(.RANGE_WIDTH(24), .CDF_SHIFT(8)) u_dut24 (
    .clk_stage_1(clk), .reset(reset), .in_valid(in_valid24), .in_ready(in_ready24),
    .FL(fl24), .FH(fh24), .SYMBOL(4'd0), .NSYMS(5'd4), .bool(1'b0),
    .out_valid(out_valid24), .out_ready(out_ready24), .UU(uu24), .VV(vv24),
    .COMP_mux_1(comp24), .bool_out(bool_out24), .out_symbol(out_symbol24),
    .lut_u_out(lu24), .lut_v_out(lv24), .illegal(illegal24), .sym_count(sym_count24)
  );

  // Reference table contents of the U/V LUTs.
  function automatic logic [31:0] exp_u(input int unsigned a);
    return (a * 37 + 11) & 32'hFFFF;
  endfunction
  function automatic logic [31:0] exp_v(input int unsigned a);
    return ((a << 5) ^ 32'hA5C3) & 32'hFFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] l, input logic [15:0] h,
                     input logic [4:0] n, input logic [3:0] s, input logic b);
    in_valid = 1'b1; fl = l; fh = h; nsyms = n; symbol = s; bool_in = b;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    fl = '0; fh = '0; nsyms = '0; symbol = '0; bool_in = 1'b0;
    in_valid24 = 1'b0; out_ready24 = 1'b1; fl24 = '0; fh24 = '0;
    step(); step();
    reset = 1'b0;
    step();

    // reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_uu", 32'(uu), 0);
    chk("rst_vv", 32'(vv), 0);
    chk("rst_comp", 32'(comp), 0);
    chk("rst_bool_out", 32'(bool_out), 0);
    chk("rst_symbol", 32'(out_symbol), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_count", sym_count, 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // basic record
    put(16'd40000, 16'd1000, 5'd4, 4'd2, 1'b0);
    step();
    in_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_uu", 32'(uu), 625);
    chk("basic_vv", 32'(vv), 15);
    chk("basic_comp", 32'(comp), 0);
    chk("basic_bool", 32'(bool_out), 1);
    chk("basic_sym", 32'(out_symbol), 2);
    chk("basic_lut_u", 32'(lu), exp_u(32'h32));
    chk("basic_lut_v", 32'(lv), exp_v(32'h32));
    chk("basic_count", sym_count, 1);
    step();
    chk("basic_drain", 32'(out_valid), 0);

    // stall for 5 cycles with a new record pending
    out_ready = 1'b0;
    put(16'd100, 16'd200, 5'd8, 4'd3, 1'b1);
    step();
    put(16'd5000, 16'd6000, 5'd16, 4'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_uu", 32'(uu), 1);
      chk("stall_vv", 32'(vv), 3);
      chk("stall_comp", 32'(comp), 1);
      chk("stall_bool", 32'(bool_out), 0);
      chk("stall_sym", 32'(out_symbol), 3);
      chk("stall_lut_u", 32'(lu), exp_u(32'h73));
      chk("stall_lut_v", 32'(lv), exp_v(32'h73));
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("next_valid", 32'(out_valid), 1);
    chk("next_uu", 32'(uu), 78);
    chk("next_vv", 32'(vv), 93);
    chk("next_sym", 32'(out_symbol), 9);
    chk("next_lut_u", 32'(lu), exp_u(32'hF9));
    chk("next_count", sym_count, 3);
    step();

    // back-to-back throughput
    pulse_reset();
    for (int s = 0; s < 16; s++) begin
      put(16'(s * 1000), 16'(s * 1000 + 64), 5'd16, 4'(s), 1'b0);
      step();
      chk("tp_valid", 32'(out_valid), 1);
      chk("tp_sym", 32'(out_symbol), 32'(s));
      chk("tp_uu", 32'(uu), 32'((s * 1000) >> 6));
      chk("tp_lut_u", 32'(lu), exp_u(32'hF0 | 32'(s)));
      chk("tp_lut_v", 32'(lv), exp_v(32'hF0 | 32'(s)));
    end
    in_valid = 1'b0;
    chk("tp_count", sym_count, 16);
    chk("tp_legal", 32'(illegal), 0);
    step();
    chk("tp_drain", 32'(out_valid), 0);

    // illegal records, sticky flag
    put(16'h1234, 16'h2000, 5'd3, 4'd5, 1'b0);
    step();
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_sym", 32'(out_symbol), 5);
    chk("ill_lut_u", 32'(lu), exp_u(32'h25));
    put(16'h1234, 16'h2000, 5'd4, 4'd1, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ill_sticky", 32'(illegal), 1);
    chk("ill_legal_lut", 32'(lu), exp_u(32'h31));
    pulse_reset();
    chk("ill_cleared", 32'(illegal), 0);
    put(16'h0, 16'h0, 5'd0, 4'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ill_nsyms0", 32'(illegal), 1);
    chk("ill_nsyms0_lut", 32'(lu), exp_u(32'hF0));
    pulse_reset();
    put(16'h0, 16'h0, 5'd17, 4'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ill_nsyms17", 32'(illegal), 1);
    step();

    // reset while stalled, with a record offered during reset
    pulse_reset();
    out_ready = 1'b0;
    put(16'd300, 16'd400, 5'd4, 4'd1, 1'b0);
    step();
    chk("mid_full", 32'(out_valid), 1);
    reset = 1'b1;
    put(16'd700, 16'd800, 5'd4, 4'd2, 1'b0);
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_count", sym_count, 0);
    chk("mid_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    step();
    chk("mid_no_emit", 32'(out_valid), 0);

    // 24-bit instance with shift 8
    in_valid24 = 1'b1; fl24 = 24'h7FFFFF; fh24 = 24'hFFFFFF;
    step();
    chk("p24_uu", 32'(uu24), 32'h7FFF);
    chk("p24_vv", 32'(vv24), 32'hFFFF);
    chk("p24_comp_lo", 32'(comp24), 1);
    fl24 = 24'h800000;
    step();
    in_valid24 = 1'b0;
    chk("p24_uu_hi", 32'(uu24), 32'h8000);
    chk("p24_comp_hi", 32'(comp24), 0);
    chk("p24_count", sym_count24, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_1_pipe.md
Name: stage_1_pipe

Overview:
- Registered, flow-controlled successor to the encoder's first stage.
- Each accepted symbol record {FL, FH, SYMBOL, NSYMS, bool} produces:
  - the CDF-shifted values UU/VV,
  - the low-half compare flag,
  - the U/V LUT words, aligned with the side-band fields and presented on a valid/ready interface.
- Adds backpressure, a parametrised probability shift, input legality checking and a symbol counter.
- Sits between the CDF fetch front end and stage 2 of the arithmetic encoder.

Parameters:
- RANGE_WIDTH, 16, width of FL/FH/UU/VV.
- SYMBOL_WIDTH, 4, symbol index width; NSYMS is SYMBOL_WIDTH+1 bits.
- LUT_DATA_WIDTH, 16, width of each LUT word.
- CDF_SHIFT, 6, right-shift applied to FL/FH (EC_PROB_SHIFT).
- CNT_WIDTH, 32, width of the accepted-symbol counter.
- Derived localparam LUT_ADDR_WIDTH = 2*SYMBOL_WIDTH; not overridable.

Ports:
- clk_stage_1  in  1  sole clock; also clocks the LUTs.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input record valid.
- in_ready  out  1  stage can accept this cycle.
- FL, FH  in  RANGE_WIDTH  CDF low/high values.
- SYMBOL  in  SYMBOL_WIDTH  symbol 0..2^SYMBOL_WIDTH-1.
- NSYMS  in  SYMBOL_WIDTH+1  number of symbols in alphabet.
- bool  in  1  boolean-symbol flag.
- out_valid  out  1  output record valid.
- out_ready  in  1  stage 2 accepts.
- UU, VV  out  RANGE_WIDTH  FL>>CDF_SHIFT, FH>>CDF_SHIFT.
- COMP_mux_1  out  1  FL < 2^(RANGE_WIDTH-1).
- bool_out  out  1  ~bool.
- out_symbol  out  SYMBOL_WIDTH  registered SYMBOL.
- lut_u_out, lut_v_out  out  LUT_DATA_WIDTH  LUT words for {NSYMS-1, SYMBOL}.
- illegal  out  1  sticky: a record with NSYMS==0, NSYMS>2^SYMBOL_WIDTH, or SYMBOL>=NSYMS was accepted.
- sym_count  out  CNT_WIDTH  number of accepted records.

Behaviour:
- Handshakes:
  - Accept on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - in_ready = ~out_valid | out_ready (combinational from out_ready; no other comb path in->out).
- Latency: exactly 1 cycle. A record accepted at edge t appears at t+1 with its LUT words; the LUTs are synchronous read with 1-cycle latency.
- LUT address:
  - addr = {(NSYMS-1)[SYMBOL_WIDTH-1:0], SYMBOL} when accepting.
  - Otherwise the held address of the current output record is re-presented, so lut_u_out/lut_v_out stay stable during stalls.
  - Address bits are truncated modulo 2^SYMBOL_WIDTH; illegal NSYMS still produces a deterministic lookup.
- Output registers (UU, VV, COMP_mux_1, bool_out, out_symbol, held addr):
  - load only on accept;
  - hold while out_valid & ~out_ready;
  - full throughput of 1 record/cycle with out_ready high.
- out_valid:
  - set on accept;
  - cleared on transfer without a simultaneous accept;
  - remains 1 on simultaneous transfer and accept.
- COMP_mux_1 threshold is 1<<(RANGE_WIDTH-1); UU/VV are logical shifts with zero fill.
- Legality:
  - evaluated on accept only;
  - illegal goes to 1 and stays until reset;
  - the offending record is still forwarded unchanged.
- sym_count: increments on every accept and wraps modulo 2^CNT_WIDTH.
- Reset (also mid-stall):
  - out_valid=0, UU=VV=0, COMP_mux_1=0, bool_out=0, out_symbol=0, illegal=0, sym_count=0, held addr=0.
  - in_ready=1 in the cycle after reset deasserts.
  - A record presented during reset is not accepted.
  - lut_*_out are don't-care while out_valid=0.
- No internal state machine beyond the single valid bit: EMPTY (out_valid=0) / FULL (out_valid=1).

Decomposition:
- Package stage_1_pkg holds:
  - default widths;
  - CDF_SHIFT default;
  - function lut_addr_f(nsyms, symbol);
  - function sym_illegal_f(nsyms, symbol).
- Reuses the existing lut_u and lut_v modules unchanged, with ADDR_WIDTH=LUT_ADDR_WIDTH.
- One natural new sub-module, stage_1_addr_hold: the address mux and held-address register.

Test Plan:
- Basic: FL=40000, FH=1000, NSYMS=4, SYMBOL=2, bool=0, out_ready=1 -> next cycle out_valid=1, UU=625, VV=15, COMP_mux_1=0, bool_out=1, out_symbol=2, LUT words = contents at addr 0x32.
- Stall: hold out_ready=0 for 5 cycles after a record with FL=100, then offer a new record -> in_ready=0; all outputs including lut_u_out/lut_v_out unchanged for 5 cycles; new record appears 1 cycle after out_ready rises.
- Throughput: 16 back-to-back records, SYMBOL=0..15, NSYMS=16, out_ready=1 -> 16 consecutive out_valid cycles, in order, correct LUT addr {0xF, s}; sym_count=16.
- Illegal: NSYMS=3, SYMBOL=5 -> record forwarded with addr 0x25, illegal=1; stays 1 after a legal record; cleared only by reset.
- Reset mid-stall: out_valid=1, out_ready=0, assert reset 1 cycle -> out_valid=0, sym_count=0, in_ready=1 next cycle; no record emitted.
- Parametrised: RANGE_WIDTH=24, CDF_SHIFT=8, FL=0x7FFFFF -> UU=0x7FFF, COMP_mux_1=1; FL=0x800000 -> COMP_mux_1=0.
